// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the two master request/response channels and the
// RAM slave channel shared by ram_arbiter.
//   master 0/1 : req, write, addr, wdata in; gnt, rvalid, rdata out
//   RAM slave  : ramaddr, ramwdata, ramenw out; ramrdata in
// Modports:
//   slave  - the arbiter's view (it serves the masters and drives the RAM)
//   master - the environment's view (masters plus RAM model)
interface ram_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0;
  logic             write0;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] wdata0;
  logic             gnt0;
  logic             rvalid0;
  logic [WIDTH-1:0] rdata0;

  logic             req1;
  logic             write1;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] wdata1;
  logic             gnt1;
  logic             rvalid1;
  logic [WIDTH-1:0] rdata1;

  logic [WIDTH-1:0] ramaddr;
  logic [WIDTH-1:0] ramwdata;
  logic             ramenw;
  logic [WIDTH-1:0] ramrdata;

  modport slave (
    input  req0, write0, addr0, wdata0,
    input  req1, write1, addr1, wdata1,
    input  ramrdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ramaddr, ramwdata, ramenw
  );

  modport master (
    output req0, write0, addr0, wdata0,
    output req1, write1, addr1, wdata1,
    output ramrdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ramaddr, ramwdata, ramenw
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port synchronous RAM
// between master 0 (core data port) and master 1 (DMA/staging engine).
// Grants are combinational; read data returns one cycle after the grant.
// A master keeps the RAM for up to MAXBURST consecutive grants while the
// other master is also requesting.
//   clk  - clkcore domain clock
//   nrst - asynchronous active-low reset
//   bus  - master channels and RAM channel (ram_arbiter_if.slave)
module ram_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAXBURST = 8
) (
  input  logic          clk,
  input  logic          nrst,
  ram_arbiter_if.slave  bus
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAXBURST);

  logic       last_q, last_d;     // most recently granted master
  logic [7:0] cnt_q, cnt_d;       // consecutive grants to last_q
  logic       rvalid0_q, rvalid0_d;
  logic       rvalid1_q, rvalid1_d;

  logic gnt0, gnt1;
  logic tie_to_m1;

  // Grant decision.
  // NOTE: every signal written in this block is defaulted first so that no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    tie_to_m1 = 1'b0;
    // NOTE: grants are combinational, so reset must gate them directly;
    // the flops alone would not silence the outputs while nrst is low.
    if (nrst) begin
      if (bus.req0 && bus.req1) begin
        // cnt = 0 means no burst is open, so the tie goes to the other
        // master; an exhausted burst also hands over.
        if (cnt_q == 8'd0 || cnt_q >= MAX_BURST_C) begin
          tie_to_m1 = ~last_q;
        end else begin
          tie_to_m1 = last_q;
        end
        gnt0 = ~tie_to_m1;
        gnt1 = tie_to_m1;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  // Burst bookkeeping and read-return tracking.
  always_comb begin
    last_d    = last_q;
    cnt_d     = 8'd0;
    rvalid0_d = gnt0 & ~bus.write0;
    rvalid1_d = gnt1 & ~bus.write1;
    if (gnt0 || gnt1) begin
      if (gnt1 == last_q) begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end else begin
        last_d = gnt1;
        cnt_d  = 8'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_q    <= 1'b1;  // master 0 wins the first tie
      cnt_q     <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // RAM mux: idle bus is driven to zero.
  always_comb begin
    bus.ramaddr  = '0;
    bus.ramwdata = '0;
    bus.ramenw   = 1'b0;
    if (gnt0) begin
      bus.ramaddr  = bus.addr0;
      bus.ramwdata = bus.wdata0;
      bus.ramenw   = bus.write0;
    end else if (gnt1) begin
      bus.ramaddr  = bus.addr1;
      bus.ramwdata = bus.wdata1;
      bus.ramenw   = bus.write1;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rvalid0_q ? bus.ramrdata : '0;
  assign bus.rdata1  = rvalid1_q ? bus.ramrdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter. The main instance uses
// MAXBURST = 4 and is backed by a small synchronous RAM model; a second
// instance with MAXBURST = 1 shows strict alternation under a held tie.
module tb_ram_arbiter;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  ram_arbiter_if #(.WIDTH(32)) bus4 ();
  ram_arbiter_if #(.WIDTH(32)) bus1 ();

  ram_arbiter #(.WIDTH(32), .MAXBURST(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus4)
  );

  ram_arbiter #(.WIDTH(32), .MAXBURST(1)) dut_b1 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model: read data one cycle after address.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (bus4.ramenw) mem[bus4.ramaddr[7:0]] <= bus4.ramwdata;
    bus4.ramrdata <= mem[bus4.ramaddr[7:0]];
  end
  assign bus1.ramrdata = '0;

  task automatic idle_all();
    bus4.req0 = 0; bus4.write0 = 0; bus4.addr0 = '0; bus4.wdata0 = '0;
    bus4.req1 = 0; bus4.write1 = 0; bus4.addr1 = '0; bus4.wdata1 = '0;
    bus1.req0 = 0; bus1.write0 = 0; bus1.addr0 = '0; bus1.wdata0 = '0;
    bus1.req1 = 0; bus1.write1 = 0; bus1.addr1 = '0; bus1.wdata1 = '0;
  endtask

  task automatic test_reset();
    #2;
    bus4.req0 = 1; bus4.addr0 = 32'h10;
    #1;
    checks++;
    if ({bus4.gnt0, bus4.gnt1} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt: got %b expected 00", {bus4.gnt0, bus4.gnt1});
    end
    checks++;
    if (bus4.ramaddr !== 32'h0 || bus4.ramenw !== 1'b0) begin
      errors++; $display("FAIL reset_ram: got addr %h enw %b expected 0 0", bus4.ramaddr, bus4.ramenw);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus4.rvalid0, bus4.rvalid1} !== 2'b00) begin
      errors++; $display("FAIL reset_rvalid: got %b expected 00", {bus4.rvalid0, bus4.rvalid1});
    end
  endtask

  // Plan item 1: first read after reset release.
  task automatic test_single_read();
    @(negedge clk);
    nrst = 1;
    #1;
    checks++;
    if ({bus4.gnt0, bus4.gnt1} !== 2'b10 || bus4.ramaddr !== 32'h10 || bus4.ramenw !== 1'b0) begin
      errors++; $display("FAIL read_grant: got gnt %b addr %h enw %b expected 10 00000010 0",
                         {bus4.gnt0, bus4.gnt1}, bus4.ramaddr, bus4.ramenw);
    end
    @(negedge clk);
    checks++;
    if (bus4.rvalid0 !== 1'b1 || bus4.rdata0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_return: got rvalid0 %b rdata0 %h expected 1 deadbeef", bus4.rvalid0, bus4.rdata0);
    end
    checks++;
    if (bus4.rvalid1 !== 1'b0 || bus4.rdata1 !== 32'h0) begin
      errors++; $display("FAIL read_other: got rvalid1 %b rdata1 %h expected 0 0", bus4.rvalid1, bus4.rdata1);
    end
    idle_all();
    #1;
    checks++;
    if (bus4.gnt0 !== 1'b0 || bus4.ramaddr !== 32'h0) begin
      errors++; $display("FAIL idle_bus: got gnt0 %b addr %h expected 0 0", bus4.gnt0, bus4.ramaddr);
    end
    @(negedge clk);
    checks++;
    if (bus4.rvalid0 !== 1'b0 || bus4.rdata0 !== 32'h0) begin
      errors++; $display("FAIL read_one_shot: got rvalid0 %b rdata0 %h expected 0 0", bus4.rvalid0, bus4.rdata0);
    end
  endtask

  // Plan item 2: both masters held from reset. Bit i = 1 means master 1
  // expected in cycle i. MAXBURST=4 gives bursts of four, MAXBURST=1 alternates.
  task automatic test_alternate();
    logic [8:0] exp4;
    logic [8:0] exp1;
    exp4 = 9'b011110000;
    exp1 = 9'b010101010;
    nrst = 0;
    bus4.req0 = 1; bus4.addr0 = 32'h10;
    bus4.req1 = 1; bus4.addr1 = 32'h14;
    bus1.req0 = 1; bus1.req1 = 1;
    @(negedge clk);
    nrst = 1;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if ({bus4.gnt0, bus4.gnt1} !== {~exp4[i], exp4[i]}) begin
        errors++; $display("FAIL burst4_seq[%0d]: got %b expected %b", i, {bus4.gnt0, bus4.gnt1}, {~exp4[i], exp4[i]});
      end
      checks++;
      if ({bus1.gnt0, bus1.gnt1} !== {~exp1[i], exp1[i]}) begin
        errors++; $display("FAIL alt1_seq[%0d]: got %b expected %b", i, {bus1.gnt0, bus1.gnt1}, {~exp1[i], exp1[i]});
      end
      @(negedge clk);
    end
    idle_all();
    @(negedge clk);
  endtask

  // Plan item 3: master 1 alone for 3 cycles, then contested; the 4th grant
  // exhausts its burst and master 0 takes over.
  task automatic test_burst_limit();
    logic [5:0] exp;
    exp = 6'b001111;
    bus4.addr0 = 32'h40;
    bus4.addr1 = 32'h44;
    for (int i = 0; i < 6; i++) begin
      bus4.req1 = 1;
      bus4.req0 = (i >= 3);
      #1;
      checks++;
      if ({bus4.gnt0, bus4.gnt1} !== {~exp[i], exp[i]} ||
          bus4.ramaddr !== (exp[i] ? 32'h44 : 32'h40)) begin
        errors++; $display("FAIL burst_limit[%0d]: got gnt %b addr %h expected %b %h", i,
                           {bus4.gnt0, bus4.gnt1}, bus4.ramaddr, {~exp[i], exp[i]}, exp[i] ? 32'h44 : 32'h40);
      end
      @(negedge clk);
    end
    idle_all();
    @(negedge clk);
  endtask

  // Plan item 4: master 0 writes, master 1 reads back the same word.
  task automatic test_write_then_read();
    bus4.req0 = 1; bus4.write0 = 1; bus4.addr0 = 32'h20; bus4.wdata0 = 32'h12345678;
    #1;
    checks++;
    if (bus4.gnt0 !== 1'b1 || bus4.ramenw !== 1'b1 || bus4.ramaddr !== 32'h20 || bus4.ramwdata !== 32'h12345678) begin
      errors++; $display("FAIL write_bus: got gnt0 %b enw %b addr %h wdata %h expected 1 1 00000020 12345678",
                         bus4.gnt0, bus4.ramenw, bus4.ramaddr, bus4.ramwdata);
    end
    @(negedge clk);
    checks++;
    if (bus4.rvalid0 !== 1'b0) begin
      errors++; $display("FAIL write_no_rvalid: got %b expected 0", bus4.rvalid0);
    end
    idle_all();
    bus4.req1 = 1; bus4.addr1 = 32'h20;
    #1;
    checks++;
    if (bus4.gnt1 !== 1'b1 || bus4.ramaddr !== 32'h20 || bus4.ramenw !== 1'b0) begin
      errors++; $display("FAIL readback_grant: got gnt1 %b addr %h enw %b expected 1 00000020 0",
                         bus4.gnt1, bus4.ramaddr, bus4.ramenw);
    end
    @(negedge clk);
    checks++;
    if (bus4.rvalid1 !== 1'b1 || bus4.rdata1 !== 32'h12345678 || bus4.rvalid0 !== 1'b0) begin
      errors++; $display("FAIL readback_data: got rvalid1 %b rdata1 %h rvalid0 %b expected 1 12345678 0",
                         bus4.rvalid1, bus4.rdata1, bus4.rvalid0);
    end
    idle_all();
    @(negedge clk);
  endtask

  // Plan item 5: master 1 requests for one contested cycle during master 0's
  // open burst, then withdraws; it must never be served.
  task automatic test_cancel();
    bus4.req0 = 1; bus4.addr0 = 32'h30;
    #1;
    checks++;
    if (bus4.gnt0 !== 1'b1) begin
      errors++; $display("FAIL cancel_open: got gnt0 %b expected 1", bus4.gnt0);
    end
    @(negedge clk);
    bus4.req1 = 1; bus4.write1 = 1; bus4.addr1 = 32'h40; bus4.wdata1 = 32'hAAAA5555;
    #1;
    checks++;
    if ({bus4.gnt0, bus4.gnt1} !== 2'b10 || bus4.ramaddr !== 32'h30 || bus4.ramenw !== 1'b0) begin
      errors++; $display("FAIL cancel_contest: got gnt %b addr %h enw %b expected 10 00000030 0",
                         {bus4.gnt0, bus4.gnt1}, bus4.ramaddr, bus4.ramenw);
    end
    @(negedge clk);
    bus4.req1 = 0; bus4.write1 = 0;
    #1;
    checks++;
    if (bus4.gnt1 !== 1'b0 || bus4.rvalid1 !== 1'b0 || bus4.ramaddr !== 32'h30) begin
      errors++; $display("FAIL cancel_drop: got gnt1 %b rvalid1 %b addr %h expected 0 0 00000030",
                         bus4.gnt1, bus4.rvalid1, bus4.ramaddr);
    end
    @(negedge clk);
    idle_all();
    checks++;
    if (bus4.rvalid1 !== 1'b0 || bus4.rvalid0 !== 1'b1 || mem[8'h40] !== 32'h0) begin
      errors++; $display("FAIL cancel_after: got rvalid1 %b rvalid0 %b mem40 %h expected 0 1 0",
                         bus4.rvalid1, bus4.rvalid0, mem[8'h40]);
    end
    @(negedge clk);
  endtask

  // Plan item 6: reset pulse right after a master 1 read grant.
  task automatic test_reset_mid_burst();
    bus4.req1 = 1; bus4.addr1 = 32'h10;
    #1;
    checks++;
    if (bus4.gnt1 !== 1'b1) begin
      errors++; $display("FAIL midrst_grant: got gnt1 %b expected 1", bus4.gnt1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus4.rvalid1 !== 1'b1) begin
      errors++; $display("FAIL midrst_pending: got rvalid1 %b expected 1", bus4.rvalid1);
    end
    nrst = 0;
    bus4.req1 = 0;
    #1;
    checks++;
    if (bus4.rvalid1 !== 1'b0 || bus4.rdata1 !== 32'h0) begin
      errors++; $display("FAIL midrst_drop: got rvalid1 %b rdata1 %h expected 0 0", bus4.rvalid1, bus4.rdata1);
    end
    @(negedge clk);
    nrst = 1;
    bus4.req0 = 1; bus4.addr0 = 32'h10;
    bus4.req1 = 1; bus4.addr1 = 32'h14;
    #1;
    checks++;
    if ({bus4.gnt0, bus4.gnt1} !== 2'b10) begin
      errors++; $display("FAIL midrst_tie: got %b expected 10", {bus4.gnt0, bus4.gnt1});
    end
    @(negedge clk);
    idle_all();
    @(negedge clk);
  endtask

  initial begin
    clk    = 0;
    nrst   = 0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    idle_all();

    test_reset();
    test_single_read();
    test_alternate();
    test_burst_limit();
    test_write_then_read();
    test_cancel();
    test_reset_mid_burst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
